// File: rtl/w0rm_core_regfile_mp.sv
// Multi-port register file with a busy scoreboard for RAW/WAW stalls, write-to-read
// bypass and a registered operand stage in front of the ALU.
module w0rm_core_regfile_mp #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_REGISTERS   = 16,
    parameter int unsigned NUM_READ_PORTS  = 2,
    parameter int unsigned NUM_WRITE_PORTS = 2,
    parameter int unsigned USER_WIDTH      = 64,
    parameter bit          ZERO_REG        = 1'b0,
    localparam int unsigned AB             = $clog2(NUM_REGISTERS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 decode_valid,
    output logic                                 decode_ready,
    input  logic [NUM_READ_PORTS*AB-1:0]         decode_src_addr,
    input  logic [AB-1:0]                        decode_dst_addr,
    input  logic                                 decode_dst_en,
    input  logic [USER_WIDTH-1:0]                user_data_in,
    output logic                                 rfetch_valid,
    input  logic                                 alu_ready,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rfetch_data,
    output logic [USER_WIDTH-1:0]                user_data_out,
    input  logic [NUM_WRITE_PORTS-1:0]           wr_en,
    input  logic [NUM_WRITE_PORTS*AB-1:0]        wr_addr,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REGISTERS-1:0]             busy_mask
);

    logic [DATA_WIDTH-1:0]                 regs_q [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0]              busy_q;
    logic [NUM_REGISTERS-1:0]              busy_d;
    logic                                  valid_q;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  data_q;
    logic [USER_WIDTH-1:0]                 user_q;

    logic [NUM_REGISTERS-1:0]              wr_hit;
    logic [DATA_WIDTH-1:0]                 wr_val [NUM_REGISTERS];
    logic [AB-1:0]                         src [NUM_READ_PORTS];
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  operands;
    logic                                  hazard;
    logic                                  accept;

    function automatic logic is_zero(input logic [AB-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Per-register effective write; ascending scan lets the highest port win.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            wr_val[r] = '0;
            for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
                if (wr_en[j] && wr_addr[j*AB +: AB] == AB'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        if (ZERO_REG) begin
            wr_hit[0] = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            src[k] = decode_src_addr[k*AB +: AB];
        end
    end

    // A busy register being written this cycle is resolved by the bypass, not a stall.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            if (busy_q[src[k]] && !wr_hit[src[k]] && !is_zero(src[k])) begin
                hazard = 1'b1;
            end
        end
        if (decode_dst_en && busy_q[decode_dst_addr] && !wr_hit[decode_dst_addr] &&
            !is_zero(decode_dst_addr)) begin
            hazard = 1'b1;
        end
    end

    assign decode_ready = !flush && !hazard && (!valid_q || alu_ready);
    assign accept       = decode_valid && decode_ready;

    always_comb begin
        operands = '0;
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            if (is_zero(src[k])) begin
                operands[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (wr_hit[src[k]]) begin
                operands[k*DATA_WIDTH +: DATA_WIDTH] = wr_val[src[k]];
            end else begin
                operands[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[src[k]];
            end
        end
    end

    // A new destination claim overrides a same-cycle clear of the same register.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (flush) begin
            busy_d = '0;
        end else if (accept && decode_dst_en && !is_zero(decode_dst_addr)) begin
            busy_d[decode_dst_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
        end else begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
            busy_q <= busy_d;
            if (flush) begin
                valid_q <= 1'b0;
                user_q  <= '0;
            end else if (accept) begin
                valid_q <= 1'b1;
                data_q  <= operands;
                user_q  <= user_data_in;
            end else if (alu_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rfetch_valid  = valid_q;
    assign rfetch_data   = data_q;
    assign user_data_out = user_q;
    assign busy_mask     = busy_q;

endmodule

// File: tb/tb_w0rm_core_regfile_mp.sv
// Directed bench for w0rm_core_regfile_mp (ZERO_REG=1) with a per-cycle model compare.
module tb_w0rm_core_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AB = 4;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int UW = 64;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              decode_valid;
    logic              decode_ready;
    logic [RP*AB-1:0]  decode_src_addr;
    logic [AB-1:0]     decode_dst_addr;
    logic              decode_dst_en;
    logic [UW-1:0]     user_data_in;
    logic              rfetch_valid;
    logic              alu_ready;
    logic [RP*DW-1:0]  rfetch_data;
    logic [UW-1:0]     user_data_out;
    logic [WP-1:0]     wr_en;
    logic [WP*AB-1:0]  wr_addr;
    logic [WP*DW-1:0]  wr_data;
    logic [NR-1:0]     busy_mask;

    int vectors     = 0;
    int miscompares = 0;

    w0rm_core_regfile_mp #(
        .DATA_WIDTH     (DW),
        .NUM_REGISTERS  (NR),
        .NUM_READ_PORTS (RP),
        .NUM_WRITE_PORTS(WP),
        .USER_WIDTH     (UW),
        .ZERO_REG       (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .decode_valid   (decode_valid),
        .decode_ready   (decode_ready),
        .decode_src_addr(decode_src_addr),
        .decode_dst_addr(decode_dst_addr),
        .decode_dst_en  (decode_dst_en),
        .user_data_in   (user_data_in),
        .rfetch_valid   (rfetch_valid),
        .alu_ready      (alu_ready),
        .rfetch_data    (rfetch_data),
        .user_data_out  (user_data_out),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy_mask      (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register array, pending-write set, operand stage.
    logic [DW-1:0]    m_mem [NR];
    logic [NR-1:0]    m_busy;
    logic             m_valid;
    logic [RP*DW-1:0] m_data;
    logic [UW-1:0]    m_user;
    bit               m_live = 1'b0;

    // {hit, value} of this cycle's write to r; later ports override, r0 is never written.
    function automatic logic [DW:0] wr_lookup(input int r);
        logic [DW:0] res = '0;
        if (r == 0) return '0;
        for (int j = 0; j < WP; j++) begin
            if (wr_en[j] && int'(wr_addr[j*AB +: AB]) == r) res = {1'b1, wr_data[j*DW +: DW]};
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] read_operand(input int a);
        logic [DW:0] w;
        if (a == 0) return '0;
        w = wr_lookup(a);
        return w[DW] ? w[DW-1:0] : m_mem[a];
    endfunction

    function automatic logic model_ready();
        logic [DW:0] w;
        int a;
        logic haz = 1'b0;
        for (int k = 0; k < RP; k++) begin
            a = int'(decode_src_addr[k*AB +: AB]);
            w = wr_lookup(a);
            if (a != 0 && m_busy[a] && !w[DW]) haz = 1'b1;
        end
        a = int'(decode_dst_addr);
        w = wr_lookup(a);
        if (decode_dst_en && a != 0 && m_busy[a] && !w[DW]) haz = 1'b1;
        return !flush && !haz && (!m_valid || alu_ready);
    endfunction

    always @(posedge clk) begin : model_p
        logic             acc;
        logic [RP*DW-1:0] ops;
        logic [NR-1:0]    nb;
        logic [DW:0]      w;
        if (reset) begin
            for (int r = 0; r < NR; r++) m_mem[r] = '0;
            m_busy  = '0;
            m_valid = 1'b0;
            m_data  = '0;
            m_user  = '0;
            m_live  = 1'b1;
        end else if (m_live) begin
            acc = decode_valid && model_ready();
            for (int k = 0; k < RP; k++) ops[k*DW +: DW] = read_operand(int'(decode_src_addr[k*AB +: AB]));
            nb = m_busy;
            for (int r = 0; r < NR; r++) begin
                w = wr_lookup(r);
                if (w[DW]) begin
                    nb[r]    = 1'b0;
                    m_mem[r] = w[DW-1:0];
                end
            end
            if (flush) begin
                m_valid = 1'b0;
                m_user  = '0;
                nb      = '0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_data  = ops;
                m_user  = user_data_in;
                if (decode_dst_en && decode_dst_addr != 0) nb[decode_dst_addr] = 1'b1;
            end else if (alu_ready) begin
                m_valid = 1'b0;
            end
            m_busy = nb;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_ready", decode_ready, model_ready());
            check("cyc_busy", busy_mask, m_busy);
            check("cyc_valid", rfetch_valid, m_valid);
            check("cyc_data", rfetch_data, m_data);
            check("cyc_user", user_data_out, m_user);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        decode_valid  = 1'b0;
        decode_dst_en = 1'b0;
        wr_en         = '0;
        flush         = 1'b0;
    endtask

    task automatic wr(input int j, input int a, input logic [DW-1:0] d);
        wr_en[j]             = 1'b1;
        wr_addr[j*AB +: AB]  = AB'(a);
        wr_data[j*DW +: DW]  = d;
    endtask

    task automatic issue(input int s0, input int s1, input bit den, input int d,
                         input logic [UW-1:0] u);
        decode_valid    = 1'b1;
        decode_src_addr = {AB'(s1), AB'(s0)};
        decode_dst_en   = den;
        decode_dst_addr = AB'(d);
        user_data_in    = u;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; decode_valid = 1'b0; decode_dst_en = 1'b0;
        decode_src_addr = '0; decode_dst_addr = '0; user_data_in = '0; alu_ready = 1'b1;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        step(); step(); reset = 1'b0;
        at_neg();
        check("rst_busy", busy_mask, 0);
        check("rst_valid", rfetch_valid, 0);
        check("rst_data", rfetch_data, 0);
        check("rst_user", user_data_out, 0);

        // Write then read back, port 1 reads an untouched register
        step(); wr(0, 3, 32'hDEADBEEF);
        step(); idle(); issue(3, 4, 1'b0, 0, 64'hA5);
        at_neg(); check("t1_ready", decode_ready, 1);
        step(); idle();
        at_neg();
        check("t1_valid", rfetch_valid, 1);
        check("t1_data", rfetch_data, {32'h0, 32'hDEADBEEF});
        check("t1_user", user_data_out, 64'hA5);

        // RAW stall on r5 released by a bypassed write
        step(); issue(0, 0, 1'b1, 5, 64'h1);
        step(); idle(); issue(5, 0, 1'b0, 0, 64'h2);
        at_neg(); check("t2_busy", busy_mask, 16'h0020); check("t2_stall", decode_ready, 0);
        step(); at_neg(); check("t2_stall2", decode_ready, 0);
        step(); wr(0, 5, 32'h1234);
        at_neg(); check("t2_bypass_ready", decode_ready, 1);
        step(); idle();
        at_neg();
        check("t2_operand", rfetch_data[31:0], 32'h1234);
        check("t2_busy_clr", busy_mask, 0);

        // Same-address writes on both ports, then a 3-cycle ALU stall
        step(); wr(0, 7, 32'h1111); wr(1, 7, 32'h2222);
        step(); idle(); issue(7, 3, 1'b0, 0, 64'h77);
        step(); idle(); alu_ready = 1'b0; issue(5, 0, 1'b0, 0, 64'h88); wr(0, 7, 32'h9999);
        at_neg();
        check("t3_port_prio", rfetch_data, {32'hDEADBEEF, 32'h2222});
        check("t4_stall0", decode_ready, 0);
        for (int i = 0; i < 2; i++) begin
            step(); wr_en = '0;
            at_neg();
            check("t4_hold_data", rfetch_data, {32'hDEADBEEF, 32'h2222});
            check("t4_hold_user", user_data_out, 64'h77);
            check("t4_stall", decode_ready, 0);
        end
        step(); alu_ready = 1'b1;
        at_neg(); check("t4_resume", decode_ready, 1);
        step(); idle();
        at_neg();
        check("t4_next_data", rfetch_data, {32'h0, 32'h1234});
        check("t4_next_user", user_data_out, 64'h88);

        // r0: write dropped, reads zero, never busy
        step(); wr(1, 0, 32'hFFFFFFFF);
        step(); idle(); issue(0, 7, 1'b1, 0, 64'h5);
        at_neg(); check("t5_ready", decode_ready, 1);
        step(); idle();
        at_neg();
        check("t5_data", rfetch_data, {32'h9999, 32'h0});
        check("t5_busy", busy_mask, 0);

        // Flush with busy r4..r7; same-cycle write still lands, offered instr dropped
        for (int r = 4; r < 8; r++) begin
            step(); idle(); issue(0, 0, 1'b1, r, 64'(r));
        end
        step(); idle(); flush = 1'b1; wr(0, 9, 32'hABCD); issue(0, 0, 1'b1, 8, 64'h99);
        at_neg();
        check("t6_busy", busy_mask, 16'h00F0);
        check("t6_valid", rfetch_valid, 1);
        check("t6_flush_ready", decode_ready, 0);
        step(); idle();
        at_neg();
        check("t6_valid0", rfetch_valid, 0);
        check("t6_user0", user_data_out, 0);
        check("t6_busy0", busy_mask, 0);
        step(); issue(9, 0, 1'b0, 0, 64'h9);
        step(); idle();
        at_neg(); check("t6_flush_wr", rfetch_data[31:0], 32'hABCD);

        // Reset in the middle of a stall
        step(); idle(); issue(3, 0, 1'b1, 2, 64'h42);
        step(); idle(); alu_ready = 1'b0; issue(2, 0, 1'b0, 0, 64'h43);
        step(); step();
        reset = 1'b1; idle();
        step(); reset = 1'b0; alu_ready = 1'b1;
        at_neg();
        check("t7_valid", rfetch_valid, 0);
        check("t7_data", rfetch_data, 0);
        check("t7_user", user_data_out, 0);
        check("t7_busy", busy_mask, 0);
        step(); issue(3, 3, 1'b0, 0, 64'h1);
        step(); idle();
        at_neg();
        check("t7_regs_clr", rfetch_data, 0);
        check("t7_valid1", rfetch_valid, 1);

        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
